// File: rtl/saradc_11b_dig_conv_seq.sv
// SAR ADC conversion sequencer: wake-up, track, 11-bit successive approximation, oversample averaging.
// Optional sticky overrun_o flag is enabled with `define SARADC_CONV_SEQ_OVERRUN_EN.
module saradc_11b_dig_conv_seq #(
    parameter int RES_W    = 11,
    parameter int STC_W    = 8,
    parameter int CHNR_W   = 5,
    parameter int WAKE_CYC = 16
) (
    input  logic              clk_i,
    input  logic              res_i,
    input  logic              mod_enable_i,
    input  logic              start_adc_i,
    input  logic [CHNR_W-1:0] chnr_i,
    input  logic [STC_W-1:0]  stc_i,
    input  logic [1:0]        overs_cfg_i,
    input  logic              comp_i,
    output logic              sample_o,
    output logic [RES_W-1:0]  dac_code_o,
    output logic              mod_ready_o,
    output logic              busy_o,
    output logic [RES_W-1:0]  result_o,
    output logic [CHNR_W-1:0] result_chnr_o,
    output logic              eoc_pre_o,
    output logic              eoc_o
`ifdef SARADC_CONV_SEQ_OVERRUN_EN
    ,
    output logic              overrun_o
`endif
);

    localparam int ACC_W  = RES_W + 3;
    localparam int WAKE_W = $clog2(WAKE_CYC + 1);
    localparam int BIT_W  = $clog2(RES_W);

    typedef enum logic [2:0] {
        S_OFF, S_WAKE, S_IDLE, S_TRACK, S_CONV, S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [WAKE_W-1:0] wake_cnt;
    logic [STC_W-1:0]  trk_cnt;
    logic [BIT_W-1:0]  bit_idx;
    logic [3:0]        samp_cnt;
    logic [RES_W-1:0]  code;
    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  acc_sum;
    logic [STC_W-1:0]  stc_lat;
    logic [1:0]        overs_lat;
    logic [CHNR_W-1:0] chnr_lat;
    logic              accept;
    logic              last_bit;
    logic              last_samp;

    // Average of 2^sh samples, truncated toward zero.
    function automatic logic [RES_W-1:0] avg_trunc(input logic [ACC_W-1:0] sum,
                                                    input logic [1:0] sh);
        logic [ACC_W-1:0] t;
        t = sum >> sh;
        return t[RES_W-1:0];
    endfunction

    assign accept    = (state == S_IDLE) && start_adc_i && mod_enable_i;
    assign last_bit  = (bit_idx == '0);
    assign last_samp = (samp_cnt == 4'd1);
    // Bit 0 of code is still clear during the last bit cycle, so OR-ing in comp_i completes it.
    assign acc_sum   = acc + ACC_W'(code | RES_W'(comp_i));

    always_ff @(posedge clk_i or posedge res_i) begin
        if (res_i) state <= S_OFF;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_OFF:   if (mod_enable_i) state_nxt = S_WAKE;
            S_WAKE:  if (wake_cnt == WAKE_W'(WAKE_CYC - 1)) state_nxt = S_IDLE;
            S_IDLE:  if (start_adc_i) state_nxt = S_TRACK;
            S_TRACK: if (trk_cnt == stc_lat) state_nxt = S_CONV;
            S_CONV:  if (last_bit) state_nxt = last_samp ? S_DONE : S_TRACK;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_OFF;
        endcase
        if (!mod_enable_i) state_nxt = S_OFF;
    end

    assign sample_o    = (state == S_TRACK);
    assign dac_code_o  = (state == S_CONV) ? (code | (RES_W'(1) << bit_idx)) : '0;
    assign mod_ready_o = (state == S_IDLE) || busy_o;
    assign busy_o      = (state == S_TRACK) || (state == S_CONV) || (state == S_DONE);
    assign eoc_pre_o   = (state == S_CONV) && last_bit && last_samp;
    assign eoc_o       = (state == S_DONE);

    always_ff @(posedge clk_i or posedge res_i) begin
        if (res_i) begin
            wake_cnt      <= '0;
            trk_cnt       <= '0;
            bit_idx       <= '0;
            samp_cnt      <= '0;
            code          <= '0;
            acc           <= '0;
            stc_lat       <= '0;
            overs_lat     <= '0;
            chnr_lat      <= '0;
            result_o      <= '0;
            result_chnr_o <= '0;
        end else begin
            case (state)
                S_OFF:  wake_cnt <= '0;
                S_WAKE: wake_cnt <= wake_cnt + 1'b1;
                S_IDLE: begin
                    if (accept) begin
                        stc_lat   <= stc_i;
                        overs_lat <= overs_cfg_i;
                        chnr_lat  <= chnr_i;
                        acc       <= '0;
                        samp_cnt  <= 4'd1 << overs_cfg_i;
                        trk_cnt   <= '0;
                    end
                end
                S_TRACK: begin
                    trk_cnt <= trk_cnt + 1'b1;
                    if (trk_cnt == stc_lat) begin
                        bit_idx <= BIT_W'(RES_W - 1);
                        code    <= '0;
                    end
                end
                S_CONV: begin
                    code[bit_idx] <= comp_i;
                    bit_idx       <= bit_idx - 1'b1;
                    if (last_bit) begin
                        acc      <= acc_sum;
                        samp_cnt <= samp_cnt - 1'b1;
                        trk_cnt  <= '0;
                        // Aborted conversions must leave the previous result untouched.
                        if (last_samp && mod_enable_i) begin
                            result_o      <= avg_trunc(acc_sum, overs_lat);
                            result_chnr_o <= chnr_lat;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SARADC_CONV_SEQ_OVERRUN_EN
    always_ff @(posedge clk_i or posedge res_i) begin
        if (res_i)                                        overrun_o <= 1'b0;
        else if (start_adc_i && busy_o)                   overrun_o <= 1'b1;
        else if (accept || (!mod_enable_i && state != S_OFF)) overrun_o <= 1'b0;
    end
`endif

endmodule

// File: tb/tb_saradc_11b_dig_conv_seq.sv
// Bench for saradc_11b_dig_conv_seq: table of conversions with a result scoreboard plus hand-written
// sequences for wake-up, ignored starts, enable drop and asynchronous reset.
module tb_saradc_11b_dig_conv_seq;
    localparam int RES_W = 11;
    localparam int STC_W = 8;
    localparam int CHNR_W = 5;
    localparam int WAKE_CYC = 16;

    logic clk = 1'b0;
    logic rst, en, start, comp;
    logic [CHNR_W-1:0] chnr;
    logic [STC_W-1:0] stc;
    logic [1:0] overs;
    logic sample, ready, busy, eoc_pre, eoc;
    logic [RES_W-1:0] dac_code, result;
    logic [CHNR_W-1:0] result_chnr;
`ifdef SARADC_CONV_SEQ_OVERRUN_EN
    logic overrun;
`endif

    saradc_11b_dig_conv_seq #(.RES_W(RES_W), .STC_W(STC_W), .CHNR_W(CHNR_W), .WAKE_CYC(WAKE_CYC)) dut (
        .clk_i(clk), .res_i(rst), .mod_enable_i(en), .start_adc_i(start),
        .chnr_i(chnr), .stc_i(stc), .overs_cfg_i(overs), .comp_i(comp),
        .sample_o(sample), .dac_code_o(dac_code), .mod_ready_o(ready), .busy_o(busy),
        .result_o(result), .result_chnr_o(result_chnr), .eoc_pre_o(eoc_pre), .eoc_o(eoc)
`ifdef SARADC_CONV_SEQ_OVERRUN_EN
        , .overrun_o(overrun)
`endif
    );

    always #5 clk = ~clk;

    // Analog model: comparator against the input code of the current sample.
    logic [RES_W-1:0] vin = '0;
    assign comp = (vin >= dac_code);

    typedef struct { logic [RES_W-1:0] res; logic [CHNR_W-1:0] ch; } exp_t;
    typedef struct { int stc; int overs; int chnr; int base; int step; int exp_res; } vec_t;

    logic [RES_W-1:0] vin_q[$];
    exp_t exp_q[$];
    int total = 0, bad = 0, eoc_cnt = 0;
    logic samp_prev = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (sample && !samp_prev && vin_q.size() > 0) vin = vin_q.pop_front();
        samp_prev = sample;
    end

    always @(negedge clk) begin
        if (eoc) begin
            exp_t e;
            eoc_cnt++;
            if (exp_q.size() == 0) begin
                chk("unexpected_eoc", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("result", result, e.res);
                chk("result_chnr", result_chnr, e.ch);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic wait_ready(output int c);
        for (c = 0; c < 100; c++) begin
            @(negedge clk);
            if (ready) break;
        end
    endtask

    task automatic start_conv(input int s, input int o, input int ch);
        @(posedge clk); #1;
        start = 1'b1;
        stc = STC_W'(s);
        overs = 2'(o);
        chnr = CHNR_W'(ch);
        @(posedge clk); #1;
        start = 1'b0;
        stc = STC_W'($urandom);
        overs = 2'($urandom);
        chnr = CHNR_W'($urandom);
    endtask

    task automatic run_conv(input vec_t v, input bit dac_chk);
        int n, scnt, pcnt, pre_c, eoc_c, dn;
        logic [RES_W-1:0] dacs[4];
        exp_t e;
        n = 1 << v.overs;
        for (int i = 0; i < n; i++) vin_q.push_back(RES_W'(v.base + i * v.step));
        e.res = RES_W'(v.exp_res);
        e.ch = CHNR_W'(v.chnr);
        exp_q.push_back(e);
        scnt = 0; pcnt = 0; pre_c = -1; eoc_c = -1; dn = 0;
        start_conv(v.stc, v.overs, v.chnr);
        for (int c = 1; c < 3000; c++) begin
            @(negedge clk);
            if (sample) scnt++;
            if (eoc_pre) begin pcnt++; pre_c = c; end
            if (busy && !sample && !eoc && dn < 4) begin dacs[dn] = dac_code; dn++; end
            if (eoc) begin eoc_c = c; break; end
        end
        chk("eoc_latency", eoc_c, n * (v.stc + 12) + 1);
        chk("track_cycles", scnt, n * (v.stc + 1));
        chk("eoc_pre_count", pcnt, 1);
        chk("eoc_pre_position", pre_c, eoc_c - 1);
        if (dac_chk) begin
            chk("dac_bit10", dacs[0], 32'h400);
            chk("dac_bit9", dacs[1], 32'h200);
            chk("dac_bit8", dacs[2], 32'h300);
            chk("dac_bit7", dacs[3], 32'h280);
        end
        @(negedge clk);
        chk("idle_after_eoc_busy", busy, 1'b0);
    endtask

    initial begin
        vec_t tab[7];
        vec_t v;
        int c, base;
        tab[0] = '{stc: 3,   overs: 0, chnr: 5,  base: 'h2A5, step: 0, exp_res: 'h2A5};
        tab[1] = '{stc: 0,   overs: 2, chnr: 7,  base: 100,   step: 1, exp_res: 101};
        tab[2] = '{stc: 0,   overs: 0, chnr: 31, base: 'h7FF, step: 0, exp_res: 'h7FF};
        tab[3] = '{stc: 1,   overs: 0, chnr: 0,  base: 0,     step: 0, exp_res: 0};
        tab[4] = '{stc: 2,   overs: 1, chnr: 3,  base: 'h400, step: 1, exp_res: 'h400};
        tab[5] = '{stc: 0,   overs: 3, chnr: 9,  base: 'h7F8, step: 1, exp_res: 'h7FB};
        tab[6] = '{stc: 255, overs: 0, chnr: 1,  base: 'h155, step: 0, exp_res: 'h155};

        rst = 1'b1; en = 1'b0; start = 1'b0; chnr = '0; stc = '0; overs = '0;
        #1;
        chk("reset_outputs", {sample, ready, busy, eoc_pre, eoc, dac_code, result, result_chnr}, 0);
`ifdef SARADC_CONV_SEQ_OVERRUN_EN
        chk("reset_overrun", overrun, 1'b0);
`endif
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        @(posedge clk); #1 en = 1'b1;
        wait_ready(c);
        chk("wake_ready_cycle", c, WAKE_CYC + 1);
        chk("wake_busy", busy, 1'b0);

        for (int i = 0; i < 7; i++) run_conv(tab[i], i == 0);

        // Start pulsed during CONV must be ignored.
        v = '{stc: 2, overs: 0, chnr: 4, base: 'h123, step: 0, exp_res: 'h123};
        base = eoc_cnt;
        vin_q.push_back(RES_W'('h123));
        exp_q.push_back('{res: RES_W'('h123), ch: CHNR_W'(4)});
        start_conv(2, 0, 4);
        for (int k = 0; k < 50 && !(busy && !sample); k++) @(negedge clk);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (40) @(negedge clk);
        chk("ignored_start_eoc_count", eoc_cnt - base, 1);
`ifdef SARADC_CONV_SEQ_OVERRUN_EN
        chk("overrun_set", overrun, 1'b1);
`endif
        v.chnr = 6;
        run_conv(v, 1'b0);
`ifdef SARADC_CONV_SEQ_OVERRUN_EN
        chk("overrun_cleared", overrun, 1'b0);
`endif

        // Disable wins over a simultaneous start in IDLE.
        @(posedge clk); #1 en = 1'b0; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        chk("prio_busy", busy, 1'b0);
        chk("prio_ready", ready, 1'b0);
        chk("prio_sample", sample, 1'b0);
        @(posedge clk); #1 en = 1'b1;
        wait_ready(c);
        chk("rewake_ready_cycle", c, WAKE_CYC + 1);

        // Enable dropped during CONV bit 5 after a result of 0x155 on channel 6 then 1.
        run_conv(tab[6], 1'b0);
        base = eoc_cnt;
        vin_q.push_back(RES_W'('h3FF));
        start_conv(0, 0, 2);
        repeat (6) @(posedge clk);
        #1;
        chk("drop_dac_bit5", dac_code, 32'h3E0);
        en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("drop_busy", busy, 1'b0);
        chk("drop_ready", ready, 1'b0);
        chk("drop_sample_dac", {sample, dac_code}, 0);
        chk("drop_result_held", result, 32'h155);
        chk("drop_chnr_held", result_chnr, 32'd1);
        repeat (20) @(negedge clk);
        chk("drop_no_eoc", eoc_cnt - base, 0);

        // Asynchronous reset during TRACK.
        @(posedge clk); #1 en = 1'b1;
        wait_ready(c);
        chk("drop_rewake_cycle", c, WAKE_CYC + 1);
        vin_q.push_back(RES_W'('h111));
        start_conv(20, 0, 6);
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_reset_outputs", {sample, ready, busy, eoc_pre, eoc, dac_code, result, result_chnr}, 0);
        vin_q.delete();
        @(posedge clk); #1 rst = 1'b0;
        wait_ready(c);
        chk("reset_rewake_cycle", c, WAKE_CYC + 1);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/saradc_11b_dig_conv_seq.md
Name: saradc_11b_dig_conv_seq

Overview:
Conversion sequencer directly downstream of the mackerel sync stage. It consumes the synchronised mod_enable level, the single-cycle start_adc pulse and the channel/sample-time/oversampling configuration. It drives the SAR sample switch and trial DAC code, and runs the 11-bit successive-approximation loop from the comparator decision. It returns mod_ready, busy, result, eoc_pre and eoc to the mackerel interface.

Parameters:
RES_W, 11, SAR result width / number of bit-decision cycles
STC_W, 8, width of sample-time count stc
CHNR_W, 5, width of channel number
WAKE_CYC, 16, analog wake-up cycles between mod_enable rise and mod_ready

Ports:
clk_i  in  1  module clock
res_i  in  1  asynchronous active-high reset
mod_enable_i  in  1  synchronised module enable (level)
start_adc_i  in  1  conversion request, single-cycle pulse
chnr_i  in  CHNR_W  channel number, sampled on accepted start
stc_i  in  STC_W  sample time; track phase lasts stc+1 cycles
overs_cfg_i  in  2  oversampling: 0/1/2/3 = 1/2/4/8 samples
comp_i  in  1  comparator decision: 1 = vin >= DAC trial level
sample_o  out  1  sample switch closed (track phase)
dac_code_o  out  RES_W  trial code to capacitive DAC
mod_ready_o  out  1  wake-up complete, accepting starts
busy_o  out  1  conversion in progress
result_o  out  RES_W  last conversion result (held)
result_chnr_o  out  CHNR_W  channel tag of result_o
eoc_pre_o  out  1  pulse one cycle before eoc_o
eoc_o  out  1  end-of-conversion pulse, result valid

Behaviour:
- Reset (res_i=1, async): state OFF; all outputs 0; accumulator, counters, and result 0.
- States: OFF, WAKE, IDLE, TRACK, CONV, DONE.
- OFF -> WAKE when mod_enable_i=1.
- WAKE: counts WAKE_CYC cycles, then goes to IDLE. mod_ready_o=1 from the first IDLE cycle.
- IDLE + start_adc_i=1: latch chnr_i, stc_i and overs_cfg_i; clear the accumulator; set the sample counter to 2^overs_cfg; go to TRACK.
- start_adc_i in any state other than IDLE is ignored.
- TRACK: sample_o=1 for exactly stc+1 cycles; dac_code_o=0. Then go to CONV.
- CONV: RES_W cycles, bit index k from RES_W-1 down to 0.
  - dac_code_o = decided bits | (1<<k).
  - comp_i sampled at the end of the cycle: 1 keeps bit k, 0 clears it.
  - After bit 0, the RES_W-bit code is added to the accumulator (RES_W+3 bits, no overflow possible).
  - If samples remain, go to TRACK; otherwise go to DONE.
- eoc_pre_o=1 during the final CONV cycle of the final sample.
- DONE: one cycle.
  - result_o = accumulator >> overs_cfg (truncate); result_chnr_o = latched chnr.
  - Both update on the DONE clock edge, so they are visible while eoc_o=1.
  - eoc_o=1 for this one cycle; then go to IDLE.
- busy_o=1 in TRACK, CONV and DONE; 0 otherwise.
- Latency, overs_cfg=0, stc=S: start seen in cycle 0; TRACK occupies cycles 1..S+1; CONV occupies cycles S+2..S+12; eoc_o in cycle S+13.
- Oversampling by N repeats TRACK+CONV N times back-to-back.
- mod_enable_i=0 in any state: go to OFF on the next edge.
  - mod_ready_o, busy_o, sample_o and dac_code_o drop that edge.
  - No eoc_o or eoc_pre_o is issued.
  - result_o and result_chnr_o keep their previous values.
- mod_enable_i=0 has priority over a simultaneous start_adc_i.
- stc=0 gives a 1-cycle track; stc=2^STC_W-1 gives a 2^STC_W-cycle track. No wrap.
- Config inputs changing during a conversion have no effect; latched copies are used.

Optional Feature:
Macro SARADC_CONV_SEQ_OVERRUN_EN.
- With the macro: extra output overrun_o (1 bit, reset 0).
  - Set sticky when start_adc_i=1 while busy_o=1.
  - Cleared on the next accepted start in IDLE.
  - On a cycle with both a clear and a set condition, the set wins.
  - Also cleared on the transition to OFF.
- Without the macro: no overrun_o port or logic; ignored starts leave no trace.

Test Plan:
- Reset then mod_enable_i=1 with WAKE_CYC=16 -> mod_ready_o rises exactly 17 cycles after enable is seen; busy_o=0.
- Single conversion, stc=3, overs=0, comp_i modelled against vin code 0x2A5 -> sample_o high for 4 cycles; dac_code_o sequence 0x400, 0x200, 0x300, 0x280, ...; eoc_o in cycle 16; result_o=0x2A5.
- Oversampling overs=2, vin codes 100, 101, 102, 103 -> 4 TRACK+CONV passes; result_o=101; eoc_pre_o exactly one cycle before eoc_o.
- start_adc_i pulsed during CONV -> ignored; exactly one eoc_o; overrun_o=1 with SARADC_CONV_SEQ_OVERRUN_EN; next accepted start clears it.
- mod_enable_i dropped at CONV bit 5 after a prior result 0x155 -> state OFF next edge; busy_o=0; no eoc_o; result_o stays 0x155.
- Async res_i asserted mid-TRACK -> all outputs 0 immediately without a clock edge; after release with mod_enable_i=1, WAKE restarts.
